// File: rtl/iob_eth_mdio_pkg.sv
// rtl/iob_eth_mdio_pkg.sv - shared MDIO state encodings, frame constants and bit counts
package iob_eth_mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam int PRE_BITS  = 32;
    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

endpackage

// File: rtl/iob_eth_mdio_if.sv
// rtl/iob_eth_mdio_if.sv - request/response bus and MDC generator handshake interfaces
interface iob_eth_mdio_if #(
    parameter int PHY_ADDR_W = 5
);
    logic                  wr;
    logic                  rd;
    logic [PHY_ADDR_W-1:0] phy_addr;
    logic [4:0]            reg_addr;
    logic [15:0]           wdata;
    logic                  busy;
    logic [15:0]           rdata;
    logic                  rdata_valid;

    modport master (output wr, rd, phy_addr, reg_addr, wdata,
                    input  busy, rdata, rdata_valid);
    modport slave  (input  wr, rd, phy_addr, reg_addr, wdata,
                    output busy, rdata, rdata_valid);
endinterface

interface iob_eth_mdc_if #(
    parameter int DIV_W = 8
);
    logic             run;
    logic [DIV_W-2:0] half;
    logic             mdc;
    logic             rise;
    logic             fall;

    modport master (output run, half, input  mdc, rise, fall);
    modport slave  (input  run, half, output mdc, rise, fall);
endinterface

// File: rtl/iob_eth_mdio_mdc_gen.sv
// rtl/iob_eth_mdio_mdc_gen.sv - MDC divider producing mdc plus single-cycle rise/fall strobes
module iob_eth_mdc_gen #(
    parameter int DIV_W = 8
) (
    input  logic          clk_i,
    input  logic          cke_i,
    input  logic          arst_i,
    iob_eth_mdc_if.slave  mdc_if
);

    logic [DIV_W-2:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             tick;

    // '>=' lets a shrinking half-period take effect at the next boundary without wrapping
    always_comb begin
        tick  = mdc_if.run && (cnt_q >= mdc_if.half - 1'b1);
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!mdc_if.run) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (cke_i) begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_if.mdc  = mdc_q;
    assign mdc_if.rise = tick && !mdc_q;
    assign mdc_if.fall = tick && mdc_q;

endmodule

// File: rtl/iob_eth_mdio.sv
// rtl/iob_eth_mdio.sv - clause-22 MDIO master; IOB_ETH_MDIO_NOPRE_EN enables nopre_i
module iob_eth_mdio
    import iob_eth_mdio_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int PHY_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic [DIV_W-1:0]      clkdiv_i,
    input  logic                  nopre_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic [PHY_ADDR_W-1:0] phy_addr_i,
    input  logic [4:0]            reg_addr_i,
    input  logic [15:0]           wdata_i,
    output logic                  busy_o,
    output logic [15:0]           rdata_o,
    output logic                  rdata_valid_o,
    output logic                  mdc_o,
    output logic                  mdio_o,
    output logic                  mdio_oe_o,
    input  logic                  mdio_i
);

    localparam int HdrBits = HDR_BITS - 5 + PHY_ADDR_W;
    localparam int FrameW  = HdrBits + TA_BITS + DATA_BITS;

    mdio_state_e       state_q, state_d;
    logic [5:0]        cnt_q, cnt_d, last_cnt;
    logic [FrameW-1:0] sr_q, sr_d, frame;
    logic              mdio_q, mdio_d;
    logic              is_wr_q, is_wr_d;
    logic [15:0]       rsr_q, rsr_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              skip_pre;
    logic [DIV_W-2:0]  half_raw, half;
    logic              unused_clkdiv_lsb;

`ifdef IOB_ETH_MDIO_NOPRE_EN
    assign skip_pre = nopre_i;
    assign unused_clkdiv_lsb = clkdiv_i[0];
`else
    assign skip_pre = 1'b0;
    assign unused_clkdiv_lsb = clkdiv_i[0] ^ nopre_i;
`endif

    assign half_raw = clkdiv_i[DIV_W-1:1];
    assign half     = (half_raw < (DIV_W-1)'(2)) ? (DIV_W-1)'(2) : half_raw;

    iob_eth_mdc_if #(.DIV_W(DIV_W)) mdc_bus ();

    assign mdc_bus.run  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign mdc_bus.half = half;

    iob_eth_mdc_gen #(.DIV_W(DIV_W)) u_mdc_gen (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .mdc_if (mdc_bus)
    );

    // Read frames carry all-ones in TA/DATA; those bits are never driven since oe is low
    assign frame = {MDIO_ST, wr_i ? OP_WR : OP_RD, phy_addr_i, reg_addr_i,
                    wr_i ? TA_WR : 2'b11, wr_i ? wdata_i : 16'hFFFF};

    always_comb begin
        last_cnt = '0;
        case (state_q)
            ST_PRE:  last_cnt = 6'(PRE_BITS - 1);
            ST_HDR:  last_cnt = 6'(HdrBits - 1);
            ST_TA:   last_cnt = 6'(TA_BITS - 1);
            ST_DATA: last_cnt = 6'(DATA_BITS - 1);
            default: last_cnt = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        mdio_d  = mdio_q;
        is_wr_d = is_wr_q;
        rsr_d   = rsr_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mdio_d = 1'b1;
                if (wr_i || rd_i) begin
                    is_wr_d = wr_i;
                    cnt_d   = '0;
                    if (skip_pre) begin
                        state_d = ST_HDR;
                        mdio_d  = frame[FrameW-1];
                        sr_d    = frame << 1;
                    end else begin
                        state_d = ST_PRE;
                        sr_d    = frame;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!is_wr_q) begin
                    rdata_d = rsr_q;
                    valid_d = 1'b1;
                end
            end
            default: begin
                if (mdc_bus.rise && state_q == ST_DATA && !is_wr_q)
                    rsr_d = {rsr_q[14:0], mdio_i};
                // Bits advance only on MDC fall so each is stable across the rising edge
                if (mdc_bus.fall) begin
                    if (state_q == ST_PRE && cnt_q != last_cnt) begin
                        mdio_d = 1'b1;
                    end else begin
                        mdio_d = sr_q[FrameW-1];
                        sr_d   = sr_q << 1;
                    end
                    if (cnt_q == last_cnt) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_PRE:  state_d = ST_HDR;
                            ST_HDR:  state_d = ST_TA;
                            ST_TA:   state_d = ST_DATA;
                            default: begin
                                state_d = ST_DONE;
                                mdio_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            mdio_q  <= 1'b1;
            is_wr_q <= 1'b0;
            rsr_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            mdio_q  <= mdio_d;
            is_wr_q <= is_wr_d;
            rsr_q   <= rsr_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = valid_q;
    assign mdc_o         = mdc_bus.mdc;
    assign mdio_o        = mdio_q;
    assign mdio_oe_o     = (state_q == ST_PRE) || (state_q == ST_HDR) ||
                           (is_wr_q && ((state_q == ST_TA) || (state_q == ST_DATA)));

endmodule
